// File: rtl/uart_rx_fifo.sv
// UART receiver with a first-word-fall-through receive FIFO and active-low RTS.
// Frames are oversampled at mid-bit; errors are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int CLK_FREQ      = 12000000,
  parameter int BAUD_RATE     = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_THRESHOLD = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic                          rts,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int TICKS = CLK_FREQ / BAUD_RATE;
  localparam int HALF  = TICKS / 2;
  localparam int CNT_W = $clog2(TICKS + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FCW   = PTR_W + 1;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(HALF);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [FCW-1:0]   FULL_CNT  = FCW'(FIFO_DEPTH);
  localparam logic [FCW-1:0]   RTS_CNT   = FCW'(RTS_THRESHOLD);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_sync;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_W-1:0]       bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_acc;
  logic                   par_ok;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [FCW-1:0]         count;
  logic [FCW-1:0]         count_next;

  logic                   tick;
  logic                   frame_done;
  logic                   pop;
  logic                   push;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept the frame.
  always_comb begin
    tick       = (cnt == TICK_LAST);
    frame_done = (state == S_STOP) && tick && rx_sync && (stop_idx == STOP_LAST);
    pop        = rd_en && data_valid;
    push       = frame_done && par_ok && ((count != FULL_CNT) || pop);
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift_reg  <= '0;
      par_acc    <= 1'b0;
      par_ok     <= 1'b1;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      cnt        <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (!rx_sync) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_CNT) begin
            if (rx_sync) begin
              state <= S_IDLE;
            end else begin
              state    <= S_DATA;
              cnt      <= '0;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              par_acc  <= 1'b0;
              par_ok   <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt       <= '0;
            shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
            par_acc   <= par_acc ^ rx_sync;
            if (bit_idx == BIT_LAST) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            cnt    <= '0;
            par_ok <= (PARITY == 1) ? (par_acc ^ rx_sync) : ~(par_acc ^ rx_sync);
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop gives half a bit of slack to catch the next start edge.
          if (tick) begin
            cnt <= '0;
            if (!rx_sync) begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end else if (stop_idx == STOP_LAST) begin
              state <= S_IDLE;
              if (!par_ok) begin
                parity_err <= 1'b1;
              end else if (!push) begin
                overrun <= 1'b1;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (rx_sync) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rts    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      rts   <= (count_next >= RTS_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

  assign data_valid = (count != '0);
  assign data_out   = data_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance driven
// by a bit-level frame generator, with hand-computed expectations.
module tb_uart_rx_fifo;

  localparam int TICKS = 12000000 / 115200;
  localparam int HALF  = TICKS / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx, rd_en, rts, data_valid, frame_err, parity_err, overrun;
  logic [7:0] data_out;
  logic [4:0] fifo_count;
  logic       rx_p, rd_en_p, rts_p, data_valid_p, frame_err_p, parity_err_p, overrun_p;
  logic [7:0] data_out_p;
  logic [4:0] fifo_count_p;

  int tests_run    = 0;
  int tests_failed = 0;
  int ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
  int ferr_cnt_p = 0, perr_cnt_p = 0, ovr_cnt_p = 0;
  int lat = -1;
  int f0, p0, o0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  uart_rx_fifo #(.PARITY(0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rts(rts), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .fifo_count(fifo_count),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  uart_rx_fifo #(.PARITY(2)) dut_p (
    .clk(clk), .reset(reset), .rx(rx_p), .rts(rts_p), .rd_en(rd_en_p),
    .data_out(data_out_p), .data_valid(data_valid_p), .fifo_count(fifo_count_p),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p)
  );

  // Error outputs are single-cycle pulses, so tally them continuously.
  always @(negedge clk) begin
    if (frame_err === 1'b1)    ferr_cnt++;
    if (parity_err === 1'b1)   perr_cnt++;
    if (overrun === 1'b1)      ovr_cnt++;
    if (frame_err_p === 1'b1)  ferr_cnt_p++;
    if (parity_err_p === 1'b1) perr_cnt_p++;
    if (overrun_p === 1'b1)    ovr_cnt_p++;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic driveRx(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx   = v;
  endtask

  task automatic sendFrame(input bit sel, input logic [7:0] data, input bit use_par,
                           input logic par_bit, input logic stop_val);
    driveRx(sel, 1'b0);
    waitCycles(TICKS);
    for (int i = 0; i < 8; i++) begin
      driveRx(sel, data[i]);
      waitCycles(TICKS);
    end
    if (use_par) begin
      driveRx(sel, par_bit);
      waitCycles(TICKS);
    end
    driveRx(sel, stop_val);
    waitCycles(TICKS);
  endtask

  task automatic popHead(input bit sel);
    if (sel) rd_en_p = 1'b1;
    else     rd_en   = 1'b1;
    waitCycles(1);
    rd_en   = 1'b0;
    rd_en_p = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    sendFrame(1'b0, v.data, 1'b0, 1'b0, v.stop);
    rx = 1'b1;
    waitCycles(TICKS);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 1'b0};

    rx = 1'b1; rx_p = 1'b1; rd_en = 1'b0; rd_en_p = 1'b0; reset = 1'b1;
    waitCycles(5);
    checkOutput("reset data_out", data_out, 0);
    checkOutput("reset data_valid", data_valid, 0);
    checkOutput("reset fifo_count", fifo_count, 0);
    checkOutput("reset rts", rts, 0);
    checkOutput("reset errors", {frame_err, parity_err, overrun}, 0);
    checkOutput("reset fifo_count_p", fifo_count_p, 0);
    reset = 1'b0;
    waitCycles(5);

    // 0xA5 with push latency measured from the start-bit edge.
    fork
      sendFrame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      for (int n = 1; n <= 10 * TICKS; n++) begin
        @(posedge clk);
        #1;
        if (lat < 0 && data_valid === 1'b1) lat = n;
      end
    join
    checkOutput("a5 latency near mid-stop",
                (lat >= 9 * TICKS + HALF - 6) && (lat <= 9 * TICKS + HALF + 10), 1);
    checkOutput("a5 data_out", data_out, 8'hA5);
    checkOutput("a5 fifo_count", fifo_count, 1);
    popHead(1'b0);
    checkOutput("a5 count after pop", fifo_count, 0);
    checkOutput("a5 valid after pop", data_valid, 0);
    if (lat < 0) lat = 9 * TICKS + HALF + 4;

    // Short glitch on an idle line is a false start.
    f0 = ferr_cnt;
    rx = 1'b0;
    waitCycles(20);
    rx = 1'b1;
    waitCycles(3 * TICKS);
    checkOutput("glitch fifo_count", fifo_count, 0);
    checkOutput("glitch no frame_err", ferr_cnt - f0, 0);
    sendFrame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    waitCycles(TICKS);
    checkOutput("post-glitch data", data_out, 8'hC3);
    popHead(1'b0);

    for (int i = 0; i < 8; i++) begin
      f0 = ferr_cnt;
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d fifo_count", i), fifo_count, {31'd0, vecs[i].exp_push});
      checkOutput($sformatf("vec%0d frame_err", i), ferr_cnt - f0, {31'd0, vecs[i].exp_ferr});
      if (vecs[i].exp_push) begin
        checkOutput($sformatf("vec%0d data_out", i), data_out, vecs[i].data);
        popHead(1'b0);
        checkOutput($sformatf("vec%0d drained", i), fifo_count, 0);
      end
    end

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right.
    sendFrame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    waitCycles(TICKS);
    checkOutput("par bad parity_err", perr_cnt_p, 1);
    checkOutput("par bad fifo_count", fifo_count_p, 0);
    sendFrame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    waitCycles(TICKS);
    checkOutput("par good fifo_count", fifo_count_p, 1);
    checkOutput("par good data", data_out_p, 8'h03);
    popHead(1'b1);
    sendFrame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    waitCycles(TICKS);
    checkOutput("par 07 data", data_out_p, 8'h07);
    checkOutput("par total errors", perr_cnt_p, 1);

    // Stop bit low, then the line held low for three frame times.
    f0 = ferr_cnt;
    sendFrame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    waitCycles(30 * TICKS);
    rx = 1'b1;
    waitCycles(2 * TICKS);
    checkOutput("break one frame_err", ferr_cnt - f0, 1);
    checkOutput("break fifo_count", fifo_count, 0);
    sendFrame(1'b0, 8'h42, 1'b0, 1'b0, 1'b1);
    waitCycles(TICKS);
    checkOutput("post-break data", data_out, 8'h42);
    checkOutput("post-break frame_err", ferr_cnt - f0, 1);
    popHead(1'b0);

    // Fill to capacity with back-to-back frames.
    o0 = ovr_cnt;
    for (int k = 0; k < 16; k++) begin
      sendFrame(1'b0, 8'h10 + 8'(k), 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("fill%0d count", k), fifo_count, k + 1);
      checkOutput($sformatf("fill%0d rts", k), rts, (k + 1 >= 12));
    end
    sendFrame(1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
    checkOutput("overrun pulse", ovr_cnt - o0, 1);
    checkOutput("overrun count", fifo_count, 16);
    checkOutput("overrun head", data_out, 8'h10);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("drain%0d head", k), data_out, 8'h10 + 8'(k));
      popHead(1'b0);
    end
    checkOutput("drain count", fifo_count, 11);
    checkOutput("drain rts", rts, 0);

    for (int k = 0; k < 5; k++) begin
      sendFrame(1'b0, 8'h20 + 8'(k), 1'b0, 1'b0, 1'b1);
    end
    checkOutput("refill count", fifo_count, 16);
    checkOutput("refill rts", rts, 1);

    // Pop lands on the exact push edge of a frame arriving into a full FIFO.
    o0 = ovr_cnt;
    fork
      sendFrame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
      begin
        repeat (lat - 1) @(posedge clk);
        #1;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
      end
    join
    checkOutput("full push+pop count", fifo_count, 16);
    checkOutput("full push+pop no overrun", ovr_cnt - o0, 0);
    checkOutput("full push+pop head", data_out, 8'h16);

    // Reset in the middle of a data bit with a full FIFO.
    f0 = ferr_cnt; p0 = perr_cnt; o0 = ovr_cnt;
    rx = 1'b0;
    waitCycles(TICKS);
    waitCycles(TICKS + HALF);
    rx = 1'b1;
    reset = 1'b1;
    waitCycles(2);
    checkOutput("midreset data_out", data_out, 0);
    checkOutput("midreset data_valid", data_valid, 0);
    checkOutput("midreset fifo_count", fifo_count, 0);
    checkOutput("midreset rts", rts, 0);
    reset = 1'b0;
    waitCycles(2 * TICKS);
    checkOutput("midreset no flags", (ferr_cnt - f0) + (perr_cnt - p0) + (ovr_cnt - o0), 0);
    checkOutput("midreset still empty", fifo_count, 0);
    sendFrame(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
    waitCycles(TICKS);
    checkOutput("post-reset count", fifo_count, 1);
    checkOutput("post-reset data", data_out, 8'h96);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
